// File: rtl/pwm_pkg.sv
// Shared mode encodings and effect helpers for the multi-channel PWM LED driver.
package pwm_pkg;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_BREATH = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  // Saturating triangle step; dir 0 = counting up, 1 = counting down.
  function automatic int unsigned fx_next_level(int unsigned level, logic dir,
                                                int unsigned max_level);
    if (dir) begin
      return (level == 0) ? 0 : level - 1;
    end
    return (level >= max_level) ? max_level : level + 1;
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: shadow/active settings, effect level state and registered compare output.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_W      = 8,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             load_i,
  input  logic [1:0]       mode_i,
  input  logic [PWM_W-1:0] duty_i,
  input  logic             apply_i,
  input  logic             fx_i,
  input  logic [PWM_W-1:0] cnt_i,
  output logic             pwm_o
);

  localparam int unsigned      MaxLvl  = (1 << PWM_W) - 1;
  localparam logic [PWM_W-1:0] AllOnes = '1;

  logic [1:0]       shd_mode_q, act_mode_q;
  logic [PWM_W-1:0] shd_duty_q, act_duty_q;
  logic [PWM_W-1:0] level_q, level_d, step;
  logic             dir_q, dir_d, phase_q, phase_d, pwm_q;

  // Both strobes are already qualified by the period boundary, so level never moves mid-period.
  always_comb begin
    level_d = level_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    step    = PWM_W'(fx_next_level(32'(level_q), dir_q, MaxLvl));
    if (apply_i) begin
      unique case (shd_mode_q)
        MODE_OFF:    level_d = '0;
        MODE_STATIC: level_d = shd_duty_q;
        MODE_BREATH: begin
          level_d = shd_duty_q;
          dir_d   = (shd_duty_q == AllOnes);
        end
        MODE_BLINK: begin
          level_d = shd_duty_q;
          phase_d = 1'b1;
        end
      endcase
    end else if (fx_i) begin
      case (act_mode_q)
        MODE_BREATH: begin
          level_d = step;
          if (step == AllOnes) begin
            dir_d = 1'b1;
          end else if (step == '0) begin
            dir_d = 1'b0;
          end
        end
        MODE_BLINK: begin
          phase_d = ~phase_q;
          level_d = phase_q ? '0 : act_duty_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      shd_mode_q <= MODE_OFF;
      shd_duty_q <= '0;
      act_mode_q <= MODE_OFF;
      act_duty_q <= '0;
      level_q    <= '0;
      dir_q      <= 1'b0;
      phase_q    <= 1'b0;
      pwm_q      <= ACTIVE_LOW;
    end else begin
      if (load_i) begin
        shd_mode_q <= mode_i;
        shd_duty_q <= duty_i;
      end
      if (apply_i) begin
        act_mode_q <= shd_mode_q;
        act_duty_q <= shd_duty_q;
      end
      level_q <= level_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      pwm_q   <= (cnt_i < level_q) ^ ACTIVE_LOW;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multich_fx.sv
// Multi-channel PWM LED driver: shared prescaler, PWM counter and effect divider feeding
// CH_NUM double-buffered channels.
module pwm_multich_fx
  import pwm_pkg::*;
#(
  parameter int unsigned CH_NUM     = 3,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned PRE_DIV    = 4,
  parameter int unsigned FX_DIV     = 16,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    iclk,
  input  logic                    irst_n,
  input  logic                    iload,
  input  logic [2*CH_NUM-1:0]     iwvmode,
  input  logic [PWM_W*CH_NUM-1:0] iwvduty,
  output logic [CH_NUM-1:0]       owvpwm,
  output logic                    osync,
  output logic                    oloaded
);

  localparam int unsigned PreW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int unsigned FxW  = (FX_DIV > 1) ? $clog2(FX_DIV) : 1;

  logic [PreW-1:0]  pre_q;
  logic [PWM_W-1:0] cnt_q;
  logic [FxW-1:0]   fxcnt_q;
  logic             pending_q, osync_q, oloaded_q;
  logic             tick, pend, fx, apply;

  assign tick  = (pre_q == PreW'(PRE_DIV - 1));
  assign pend  = tick & (cnt_q == '1);
  assign fx    = pend & (fxcnt_q == FxW'(FX_DIV - 1));
  assign apply = pend & pending_q;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      fxcnt_q   <= '0;
      pending_q <= 1'b0;
      osync_q   <= 1'b0;
      oloaded_q <= 1'b0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (pend) begin
        fxcnt_q <= fx ? '0 : fxcnt_q + 1'b1;
      end
      // A load on the boundary cycle keeps pending set for the next period.
      if (iload) begin
        pending_q <= 1'b1;
      end else if (pend) begin
        pending_q <= 1'b0;
      end
      osync_q   <= pend;
      oloaded_q <= apply;
    end
  end

  assign osync   = osync_q;
  assign oloaded = oloaded_q;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_chan
    pwm_chan #(
      .PWM_W      (PWM_W),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .iclk    (iclk),
      .irst_n  (irst_n),
      .load_i  (iload),
      .mode_i  (iwvmode[2*k +: 2]),
      .duty_i  (iwvduty[PWM_W*k +: PWM_W]),
      .apply_i (apply),
      .fx_i    (fx),
      .cnt_i   (cnt_q),
      .pwm_o   (owvpwm[k])
    );
  end

endmodule

// File: doc/pwm_multich_fx.md
Name: pwm_multich_fx

Overview:
- Parametrised multi-channel PWM LED driver; successor to the fixed 3-channel saw/triangle breathing generator.
- One shared timebase (prescaler, PWM counter, effect divider) drives CH_NUM channels.
- Each channel has a runtime-selectable mode (OFF/STATIC/BREATH/BLINK) and an 8-bit-class duty.
- Settings are double-buffered and applied only at PWM period boundaries, so outputs never glitch.
- Sits between the board LED pins and a control FSM or register block.

Parameters:
CH_NUM, 3, number of PWM channels (>=1)
PWM_W, 8, duty/counter resolution; period = 2^PWM_W ticks
PRE_DIV, 4, iclk cycles per PWM tick (>=1; 1 = tick every cycle)
FX_DIV, 16, PWM periods per breath step / per blink half-phase (>=1)
ACTIVE_LOW, 1, output polarity; 1 = LED lit when pin is 0

Ports:
iclk  in  1  system clock
irst_n  in  1  reset; asynchronous, active-low
iload  in  1  1-cycle strobe; captures iwvmode/iwvduty into shadow registers
iwvmode  in  2*CH_NUM  per-channel mode, ch k at [2k+1:2k]
iwvduty  in  PWM_W*CH_NUM  per-channel duty or start level, ch k at [PWM_W*k +: PWM_W]
owvpwm  out  CH_NUM  registered PWM outputs, polarity per ACTIVE_LOW
osync  out  1  1-cycle pulse, first cycle of each PWM period
oloaded  out  1  1-cycle pulse when shadow settings become active

Behaviour:
- Reset (async): all counters = 0; active and shadow mode = OFF; duty and level = 0; pending = 0; owvpwm = {CH_NUM{ACTIVE_LOW}} (unlit); osync = 0; oloaded = 0.
- Prescaler: counts 0..PRE_DIV-1; tick = (pre == PRE_DIV-1).
- PWM counter (PWM_W bits):
  - Increments on tick and wraps naturally from 2^PWM_W-1 to 0.
  - pend = tick & (cnt == all-ones).
  - osync is registered from pend, so it is high in the cycle cnt first reads 0.
- Effect divider: counts pend events 0..FX_DIV-1; fx = pend & (fxcnt == FX_DIV-1). It is shared by all channels and is never reset by a load.
- Load (double-buffer):
  - iload writes shadow mode/duty and sets pending.
  - A repeated iload before the boundary overwrites the shadow; last write wins.
  - On pend with pending = 1: active <- shadow, pending cleared, oloaded pulses on the next cycle.
  - If iload coincides with pend: active takes the old shadow, the shadow takes the new values, and pending stays 1. The new values apply at the following boundary.
- Per-channel level, updated only on pend so it is constant within a period:
  - OFF (0): level = 0.
  - STATIC (1): level = active duty.
  - BREATH (2):
    - On apply: level <- duty; dir = up, or down if duty is all-ones.
    - On each fx: level ±1. Reaching all-ones sets dir down; reaching 0 sets dir up.
    - Each extreme is held for exactly FX_DIV periods, with no overshoot and no wrap.
  - BLINK (3):
    - On apply: phase = on.
    - On each fx: phase toggles.
    - level = duty when on, 0 when off.
  - A mode/duty apply and an fx in the same cycle: apply wins and that fx is ignored for the channel.
- Compare: raw = (cnt < level); owvpwm[k] <= raw ^ ACTIVE_LOW. Output latency is 1 cycle after cnt.
  - level 0 → never lit.
  - level all-ones → lit 2^PWM_W-1 of 2^PWM_W ticks.
- Reset mid-period: outputs go unlit immediately; after release all channels remain OFF until an iload is applied.

Decomposition:
- Package pwm_pkg holds:
  - mode constants MODE_OFF=2'd0, MODE_STATIC=2'd1, MODE_BREATH=2'd2, MODE_BLINK=2'd3;
  - function fx_next_level(level, dir, max), which returns the saturating triangle step.
- Sub-module pwm_chan, generated CH_NUM times, contains shadow/active regs, level/dir/phase state, and the compare/output register.
- The top module holds the prescaler, PWM counter, effect divider, the pending flag, osync and oloaded.

Test Plan (CH_NUM=3, PWM_W=4, PRE_DIV=1, FX_DIV=2, ACTIVE_LOW=0 unless noted):
- Reset, then release with no load → owvpwm=000 permanently; osync pulses every 16 cycles; oloaded stays 0.
- iload ch0 STATIC duty 4, ch1 STATIC 0, ch2 STATIC 15 → at the next boundary oloaded=1 for 1 cycle. Thereafter per 16-cycle period: ch0 high 4 cycles, ch1 high 0, ch2 high 15.
- iload ch0 BREATH duty 0 → per-period high counts follow 0,0,1,1,2,2,...,15,15,14,14,...,0,0,1, with no value above 15 and no wrap.
- iload duty 3 then iload duty 9 in the same period → only 9 is applied. An iload asserted exactly on the pend cycle → applied one period later, oloaded pulses twice in total.
- ch1 BLINK duty 8 → repeating pattern of 2 periods high 8/16 then 2 periods high 0. With ACTIVE_LOW=1 the same pattern appears inverted.
- Assert irst_n=0 mid-period while ch0 STATIC 4 is lit → owvpwm=000 (or 111 when ACTIVE_LOW=1) in the same cycle; after release all channels stay OFF until the next iload plus boundary.
